// File: rtl/flow_meter_pkg.sv
// flow_meter_pkg: shared widths, default window limits and typedefs for the
// flow-window monitor.
package flow_meter_pkg;

  localparam int FLOW_W            = 6;
  localparam int SENSOR_W          = 5;
  localparam int FLOW_LOW_DEFAULT  = 20;
  localparam int FLOW_HIGH_DEFAULT = 50;

  typedef logic [FLOW_W-1:0]   flow_rate_t;
  typedef logic [SENSOR_W-1:0] sensor_code_t;

endpackage

// File: rtl/flow_therm_check.sv
// flow_therm_check: combinational thermometer-code validator. A code is valid
// when its set bits form one contiguous run starting at bit 0 (including
// all-zeros and all-ones).
module flow_therm_check
  import flow_meter_pkg::*;
(
  input  sensor_code_t i_code,
  output logic         o_valid
);

  // Width-limited increment: all-ones wraps to zero, so 11111 also passes.
  sensor_code_t w_inc;

  // Adding one to a thermometer code clears the whole run, so no bit overlaps.
  always_comb begin
    w_inc   = i_code + sensor_code_t'(1);
    o_valid = ((i_code & w_inc) == '0);
  end

endmodule

// File: rtl/flow_meter.sv
// flow_meter: registers a flow-in-window flag (Z) from the 6-bit flow rate and
// a sensor-fault flag (Y) from the 5-bit thermometer sensor bank.
// Optional feature macro: FLOWMETER_SENSOR_CHECK_EN enables the sensor-code
// validator; without it Y is held at 0 and ABCDE is ignored.
module flow_meter
  import flow_meter_pkg::*;
#(
  parameter int LOW_LIMIT  = FLOW_LOW_DEFAULT,
  parameter int HIGH_LIMIT = FLOW_HIGH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SENSOR_W-1:0] ABCDE,
  input  logic [FLOW_W-1:0]   flow_rate,
  output logic                Y,
  output logic                Z
);

  // Window bounds must be ordered and representable in the flow-rate width.
  if (LOW_LIMIT < 0 || LOW_LIMIT > HIGH_LIMIT || HIGH_LIMIT > 63) begin : g_bad_limits
    $error("flow_meter: need 0 <= LOW_LIMIT <= HIGH_LIMIT <= 63");
  end

  localparam flow_rate_t LO = flow_rate_t'(LOW_LIMIT);
  localparam flow_rate_t HI = flow_rate_t'(HIGH_LIMIT);

  logic r_y;
  logic r_z;
  logic w_z_next;
  logic w_y_next;

  // Inclusive unsigned window compare.
  always_comb begin
    w_z_next = (flow_rate >= LO) && (flow_rate <= HI);
  end

`ifdef FLOWMETER_SENSOR_CHECK_EN
  logic w_code_valid;

  flow_therm_check u_therm (
    .i_code  (sensor_code_t'(ABCDE)),
    .o_valid (w_code_valid)
  );

  // Fault whenever the sensor bank is not a thermometer code.
  always_comb begin
    w_y_next = ~w_code_valid;
  end
`else
  // Sensor bank is deliberately ignored in this build.
  logic w_unused_abcde;
  assign w_unused_abcde = ^ABCDE;

  // No validator: the fault flop only ever loads 0.
  always_comb begin
    w_y_next = 1'b0;
  end
`endif

  // Output flops, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y <= 1'b0;
      r_z <= 1'b0;
    end else begin
      r_y <= w_y_next;
      r_z <= w_z_next;
    end
  end

  assign Y = r_y;
  assign Z = r_z;

endmodule

// File: tb/tb_flow_meter.sv
// tb_flow_meter: table-driven check of flow_meter with a scoreboard queue,
// plus hand-written asynchronous reset sequences.
module tb_flow_meter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] ABCDE = 5'b00000;
  logic [5:0] flow_rate = 6'd30;
  logic       Y;
  logic       Z;

  int checks = 0;
  int errors = 0;

`ifdef FLOWMETER_SENSOR_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  flow_meter #(.LOW_LIMIT(20), .HIGH_LIMIT(50)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ABCDE     (ABCDE),
    .flow_rate (flow_rate),
    .Y         (Y),
    .Z         (Z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] abcde;
    logic [5:0] flow;
    logic       y;   // fault expected when the validator is built in
    logic       z;
  } vec_t;

  typedef struct {
    string name;
    logic  y;
    logic  z;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] a, input logic [5:0] f, input logic y, input logic z);
    vec_t v;
    v.abcde = a; v.flow = f; v.y = y; v.z = z;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, push expectation, compare just after the
  // next rising edge.
  task automatic apply(input string name, input logic [4:0] a, input logic [5:0] f,
                       input logic y, input logic z);
    exp_t e;
    @(negedge clk);
    ABCDE     = a;
    flow_rate = f;
    e.name = name; e.y = y & CHK_EN; e.z = z;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard_empty actual=0 expected=1", name);
    end else begin
      e = sb.pop_front();
      chk({e.name, ".Y"}, Y, e.y);
      chk({e.name, ".Z"}, Z, e.z);
    end
  endtask

  initial begin
    // window sweep with a clean sensor code
    add(5'b00000, 6'd8,  0, 0);
    add(5'b00000, 6'd10, 0, 0);
    add(5'b00000, 6'd19, 0, 0);
    add(5'b00000, 6'd20, 0, 1);
    add(5'b00000, 6'd30, 0, 1);
    add(5'b00000, 6'd40, 0, 1);
    add(5'b00000, 6'd50, 0, 1);
    add(5'b00000, 6'd51, 0, 0);
    add(5'b00000, 6'd60, 0, 0);
    // every valid thermometer code
    add(5'b00000, 6'd30, 0, 1);
    add(5'b00001, 6'd30, 0, 1);
    add(5'b00011, 6'd30, 0, 1);
    add(5'b00111, 6'd30, 0, 1);
    add(5'b01111, 6'd30, 0, 1);
    add(5'b11111, 6'd30, 0, 1);
    // malformed codes
    add(5'b00010, 6'd30, 1, 1);
    add(5'b10101, 6'd30, 1, 1);
    add(5'b11110, 6'd30, 1, 1);
    add(5'b01000, 6'd30, 1, 1);
    // extremes
    add(5'b00000, 6'd0,  0, 0);
    add(5'b00000, 6'd63, 0, 0);
    add(5'b11111, 6'd60, 0, 0);

    // asynchronous reset with no clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("reset.Y", Y, 1'b0);
    chk("reset.Z", Z, 1'b0);
    @(negedge clk);
    chk("reset_hold.Z", Z, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release.Z", Z, 1'b1);
    chk("release.Y", Y, 1'b0);

    foreach (vecs[i])
      apply($sformatf("vec%0d", i), vecs[i].abcde, vecs[i].flow, vecs[i].y, vecs[i].z);

    // mid-run reset pulse between edges
    apply("pre_mid", 5'b10101, 6'd30, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset.Y", Y, 1'b0);
    chk("mid_reset.Z", Z, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("recover.Y", Y, CHK_EN);
    chk("recover.Z", Z, 1'b1);

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
